// File: rtl/matrix_scan_ctrl.sv
// Five-column 2-of-5 display scanner: holds each column for SCAN_DIV clocks and latches code/valid at every frame start.
// Optional err blinking is built only when BLINK_EN is defined (phase period BLINK_FRAMES frames).
module matrix_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] code,
  input  logic       valid,
  output logic [4:0] col,
  output logic       col_data,
  output logic       frame_start,
  output logic       err
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20) || BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_cfg
    $error("matrix_scan_ctrl: SCAN_DIV or BLINK_FRAMES out of range");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [4:0]    lat_code;
  logic          lat_valid;

  logic          tc;
  logic          wrap;
  logic          cap;
  logic [2:0]    nidx;
  logic          adv_bit;
  logic          cap_err;

  assign tc      = (cnt == CW'(SCAN_DIV - 1));
  assign wrap    = tc && (idx == 3'd4);
  // A capture happens on scan entry and on every e->a wrap, never when en is low.
  assign cap     = en && ((state == IDLE) || ((state == SCAN) && wrap));
  assign nidx    = wrap ? 3'd0 : idx + 3'd1;
  assign adv_bit = lat_code[3'd4 - nidx];

`ifdef BLINK_EN
  logic [7:0] fcnt;
  logic [7:0] cap_fcnt;
  logic       blink;
  logic       cap_blink;

  // fcnt==0 marks "no invalid run in progress", so the next invalid frame restarts the phase at 1.
  always_comb begin
    cap_fcnt  = fcnt;
    cap_blink = blink;
    if (valid) begin
      cap_fcnt  = 8'd0;
      cap_blink = 1'b0;
    end else if (fcnt == 8'd0) begin
      cap_fcnt  = 8'd1;
      cap_blink = 1'b1;
    end else if (fcnt == 8'(BLINK_FRAMES)) begin
      cap_fcnt  = 8'd1;
      cap_blink = ~blink;
    end else begin
      cap_fcnt  = fcnt + 8'd1;
    end
  end

  assign cap_err = cap_blink;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      fcnt  <= 8'd0;
      blink <= 1'b0;
    end else if (cap) begin
      fcnt  <= cap_fcnt;
      blink <= cap_blink;
    end
  end
`else
  assign cap_err = ~valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      lat_code    <= 5'b00000;
      lat_valid   <= 1'b0;
      col         <= 5'b00000;
      col_data    <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else if (!en) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      col         <= 5'b00000;
      col_data    <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else if (cap) begin
      // The captured word drives column a in the same cycle as frame_start.
      state       <= SCAN;
      cnt         <= '0;
      idx         <= 3'd0;
      lat_code    <= code;
      lat_valid   <= valid;
      col         <= 5'b10000;
      col_data    <= code[4] & valid;
      frame_start <= 1'b1;
      err         <= cap_err;
    end else begin
      frame_start <= 1'b0;
      if (tc) begin
        cnt      <= '0;
        idx      <= nidx;
        col      <= 5'b10000 >> nidx;
        col_data <= adv_bit & lat_valid;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_matrix_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:0] code;
  logic       valid;
  logic [4:0] col;
  logic       col_data;
  logic       frame_start;
  logic       err;

  int checks = 0;
  int errors = 0;

  matrix_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .code(code), .valid(valid),
    .col(col), .col_data(col_data), .frame_start(frame_start), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_col"}, 32'(col), 32'd0);
    chk({tag, "_cd"}, 32'(col_data), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Runs n cycles of a frame (from its capture edge); optionally changes inputs after cycle chg+1.
  task automatic frame(input string tag, input logic [4:0] ec, input logic ev, input logic ee,
                       input int n, input int chg, input logic [4:0] nc, input logic nv);
    logic [4:0] c;
    for (int k = 0; k < n; k++) begin
      tick();
      c = 5'b10000 >> (k / 4);
      chk($sformatf("%s_col_%0d", tag, k), 32'(col), 32'(c));
      chk($sformatf("%s_cd_%0d", tag, k), 32'(col_data), 32'((|(ec & c)) & ev));
      chk($sformatf("%s_fs_%0d", tag, k), 32'(frame_start), 32'(k == 0));
      chk($sformatf("%s_err_%0d", tag, k), 32'(err), 32'(ee));
      if (k == chg) begin
        code  = nc;
        valid = nv;
      end
    end
  endtask

  logic blink_exp [5];

  initial begin
`ifdef BLINK_EN
    blink_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    blink_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst = 1'b1; en = 1'b0; code = 5'b10101; valid = 1'b1;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("idle");

    // Basic frame, then wrap with a second frame_start.
    code = 5'b11000; valid = 1'b1; en = 1'b1;
    frame("f1", 5'b11000, 1'b1, 1'b0, 20, -1, 5'b0, 1'b0);
    // Code changes at cycle 6 must not show until the next capture.
    frame("f2", 5'b11000, 1'b1, 1'b0, 20, 5, 5'b00011, 1'b1);
    frame("f3", 5'b00011, 1'b1, 1'b0, 20, 10, 5'b11100, 1'b0);

    // Invalid word: dark pixels, err steady or blinking in 2-frame blocks.
    for (int f = 0; f < 5; f++)
      frame($sformatf("inv%0d", f), 5'b11100, 1'b0, blink_exp[f], 20, -1, 5'b0, 1'b0);

    // en dropped exactly at the c->d advance.
    code = 5'b11000; valid = 1'b1;
    frame("pre_off", 5'b11000, 1'b1, 1'b0, 12, -1, 5'b0, 1'b0);
    en = 1'b0;
    tick();
    chk_zero("en_off_adv");
    tick();
    chk_zero("en_off_hold");
    en = 1'b1;
    frame("reen", 5'b11000, 1'b1, 1'b0, 20, -1, 5'b0, 1'b0);

    // en dropped exactly at the e->a wrap: no capture, no pulse.
    code = 5'b00111;
    en = 1'b0;
    tick();
    chk_zero("en_off_wrap");
    en = 1'b1;
    frame("after_wrap", 5'b00111, 1'b1, 1'b0, 6, -1, 5'b0, 1'b0);

    // Reset pulse mid-column with en held.
    code = 5'b10001;
    rst = 1'b1;
    tick();
    chk_zero("mid_rst");
    rst = 1'b0;
    frame("post_rst", 5'b10001, 1'b1, 1'b0, 20, -1, 5'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 SCAN_DIV, default 50000, clocks each column is held active (dwell); legal range 2..2^20.
REQ-002 BLINK_FRAMES, default 32, frames per err blink phase; used only when BLINK_EN is defined; legal range 1..255.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 en  input  1  scan enable; 1 = scan the matrix, 0 = blank it.
REQ-006 code  input  5  2-of-5 code, code[4]=a (MSB) ... code[0]=e (LSB).
REQ-007 valid  input  1  validator result for code; 1 = legal 2-of-5 word.
REQ-008 col  output  5  one-hot column drive, active-high; col[4]=column a.
REQ-009 col_data  output  1  pixel state for the active column; 1 = lit.
REQ-010 frame_start  output  1  one-cycle pulse on each capture of code/valid.
REQ-011 err  output  1  invalid-code indicator for the current frame.

Function
REQ-012 The block SHALL use two states, IDLE and SCAN; in IDLE, col, col_data, frame_start and err SHALL be 0.
REQ-013 IDLE->SCAN SHALL occur at the first edge that samples en=1; col SHALL be 5'b10000 in the cycle after that edge.
REQ-014 SCAN->IDLE SHALL occur at the first edge that samples en=0; all outputs SHALL be 0 in the following cycle. The dwell counter and column index SHALL be cleared.
REQ-015 In SCAN, a dwell counter SHALL count 0..SCAN_DIV-1. At terminal count the column SHALL advance a->b->c->d->e and wrap e->a. A frame SHALL be exactly 5*SCAN_DIV cycles.
REQ-016 code and valid SHALL be latched on entry to column a. This covers IDLE->SCAN entry and every e->a wrap. frame_start SHALL be 1 in the first cycle col=10000 is driven.
REQ-017 Changes on code or valid between captures SHALL NOT affect col_data or err until the next capture.
REQ-018 col_data SHALL equal the latched code bit selected by col, ANDed with the latched valid. An invalid word SHALL never light a pixel.
REQ-019 err SHALL be the inverse of the latched valid while in SCAN, subject to REQ-026.
REQ-020 col SHALL be one-hot or all-zero in every cycle; two bits high at once is a failure.
REQ-021 If en falls at the same edge as a column advance or wrap, IDLE SHALL take priority. No capture and no frame_start pulse SHALL occur.
REQ-022 All outputs SHALL be registered. Latency from a captured word to its col_data on column a SHALL be 0 cycles after the capture edge (same cycle as frame_start).

Reset
REQ-023 rst=1 SHALL force IDLE, clear the dwell counter, column index, latched code (5'b00000), latched valid (0) and blink state, and drive all outputs to 0 at the next edge.
REQ-024 rst SHALL take priority over en. Reset asserted mid-frame SHALL abort the frame with no frame_start pulse.
REQ-025 After rst falls with en=1, scanning SHALL restart per REQ-013 from column a with a fresh capture.

Configuration
REQ-026 BLINK_EN defined: err SHALL toggle every BLINK_FRAMES frames while the latched valid is 0. The blink phase SHALL start at 1 on the first invalid frame, and the phase counter SHALL clear on any valid frame or in IDLE. BLINK_EN undefined: err SHALL be steady per REQ-019 and the blink logic SHALL NOT be instantiated.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-027 rst, then en=1 with code=5'b11000, valid=1 -> col 10000 for 4 cycles with col_data=1 and frame_start=1 in cycle 1 only; then 01000 for 4 cycles with col_data=1; then 00100, 00010 and 00001 with col_data=0; then wrap to 10000 at cycle 21 with a second frame_start.
REQ-028 code changes 11000->00011 at cycle 6 of a frame -> the current frame still shows 11000; the next frame shows col_data=1 on columns d and e only.
REQ-029 code=5'b11100, valid=0 -> col_data=0 on all columns and err=1. With BLINK_EN, err is 1,1,0,0,1... in frame-sized blocks (2 frames each).
REQ-030 en dropped at the cycle of the c->d advance -> the next cycle has col=0 and all outputs 0. On re-enable, col=10000 with frame_start=1.
REQ-031 rst=1 pulsed mid-column with en=1 held -> all outputs 0 the next cycle, no frame_start; scanning restarts at column a one cycle after rst falls.
